// File: rtl/prog_loader_pkg.sv
// Shared constants and state encodings for the serial program loader.
// Loader state values double as the LED debug code, so keep them fixed.
package prog_loader_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SYNC   = 3'd1,
        LEN_HI = 3'd2,
        LEN_LO = 3'd3,
        DATA   = 3'd4,
        CSUM   = 3'd5,
        DONE   = 3'd6,
        ERROR  = 3'd7
    } ld_state_e;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_e;

endpackage

// File: rtl/prog_loader_if.sv
// Instruction-memory write port driven by the loader.
interface prog_loader_if;

    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic        mem_we;

    modport master (output mem_addr, output mem_data, output mem_we);
    modport slave  (input  mem_addr, input  mem_data, input  mem_we);

endinterface

// File: rtl/prog_loader_uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling, glitch-rejecting start check.
//
// state    | meaning
// RX_IDLE  | waiting for a falling edge on the synchronized line
// RX_START | re-checking the start bit half a bit period later
// RX_DATA  | sampling 8 data bits, LSB first
// RX_STOP  | sampling the stop bit; pulse rx_valid or frame_err
module uart_rx
    import prog_loader_pkg::*;
#(
    parameter int unsigned CLK_HZ = 50_000_000,
    parameter int unsigned BAUD   = 115_200
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rxd,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       frame_err
);

    localparam int unsigned DIV = CLK_HZ / BAUD;
    localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_M1 = CW'((DIV / 2) - 1);

    rx_state_e   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic        sync1_q, sync1_d;
    logic        sync2_q, sync2_d;
    logic        prev_q, prev_d;
    logic        rx_valid_q, rx_valid_d;
    logic        frame_err_q, frame_err_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= RX_IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            prev_q      <= 1'b1;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            prev_q      <= prev_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        sync1_d     = rxd;
        sync2_d     = sync1_q;
        prev_d      = sync2_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;

        case (state_q)
            RX_IDLE: begin
                if (prev_q && !sync2_q) begin
                    state_d = RX_START;
                    cnt_d   = HALF_M1;
                end
            end
            RX_START: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (!sync2_q) begin
                    state_d = RX_DATA;
                    cnt_d   = DIV_M1;
                    bit_d   = '0;
                end else begin
                    state_d = RX_IDLE;
                end
            end
            RX_DATA: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    shift_d = {sync2_q, shift_q[7:1]};
                    cnt_d   = DIV_M1;
                    if (bit_q == 3'd7) state_d = RX_STOP;
                    else               bit_d   = bit_q + 3'd1;
                end
            end
            RX_STOP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    rx_valid_d  = sync2_q;
                    frame_err_d = !sync2_q;
                    state_d     = RX_IDLE;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    assign rx_byte   = shift_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;

endmodule

// File: rtl/prog_loader.sv
// Serial program loader: receives a framed image over UART and writes big-endian words
// into instruction memory, holding the CPU in reset while a load is in flight.
//
// state  | meaning
// IDLE   | after reset; only a sync byte is acted on
// SYNC   | sync seen, waiting for LEN_HI
// LEN_HI | waiting for LEN_LO
// LEN_LO | one-cycle length check
// DATA   | assembling words and strobing writes
// CSUM   | waiting for the checksum byte
// DONE   | frame accepted; sync byte restarts
// ERROR  | frame rejected; sync byte restarts
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int unsigned CLK_HZ      = 50_000_000,
    parameter int unsigned BAUD        = 115_200,
    parameter logic [31:0] BASE_ADDR   = 32'h0,
    parameter int unsigned MAX_WORDS   = 256,
    parameter int unsigned TIMEOUT_CYC = 5_000_000
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 uart_rxd,
    prog_loader_if.master        mem,
    output logic                 cpu_hold,
    output logic                 load_done,
    output logic                 load_err,
    output logic [15:0]          words_loaded,
    output logic [2:0]           state_dbg
);

    localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] TMO_RELOAD = TW'(TIMEOUT_CYC - 1);

    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       frame_err;

    uart_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) u_rx (
        .clock     (clock),
        .reset     (reset),
        .rxd       (uart_rxd),
        .rx_byte   (rx_byte),
        .rx_valid  (rx_valid),
        .frame_err (frame_err)
    );

    ld_state_e   state_q, state_d;
    logic [15:0] len_q, len_d;
    logic [7:0]  csum_q, csum_d;
    logic [23:0] word_q, word_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_data_q, mem_data_d;
    logic        mem_we_q, mem_we_d;
    logic        cpu_hold_q, cpu_hold_d;
    logic        load_done_q, load_done_d;
    logic        load_err_q, load_err_d;
    logic [15:0] words_loaded_q, words_loaded_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic        active;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= IDLE;
            len_q          <= '0;
            csum_q         <= '0;
            word_q         <= '0;
            byte_cnt_q     <= '0;
            mem_addr_q     <= BASE_ADDR;
            mem_data_q     <= '0;
            mem_we_q       <= 1'b0;
            cpu_hold_q     <= 1'b0;
            load_done_q    <= 1'b0;
            load_err_q     <= 1'b0;
            words_loaded_q <= '0;
            tmo_q          <= TMO_RELOAD;
        end else begin
            state_q        <= state_d;
            len_q          <= len_d;
            csum_q         <= csum_d;
            word_q         <= word_d;
            byte_cnt_q     <= byte_cnt_d;
            mem_addr_q     <= mem_addr_d;
            mem_data_q     <= mem_data_d;
            mem_we_q       <= mem_we_d;
            cpu_hold_q     <= cpu_hold_d;
            load_done_q    <= load_done_d;
            load_err_q     <= load_err_d;
            words_loaded_q <= words_loaded_d;
            tmo_q          <= tmo_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        len_d          = len_q;
        csum_d         = csum_q;
        word_d         = word_q;
        byte_cnt_d     = byte_cnt_q;
        mem_addr_d     = mem_addr_q;
        mem_data_d     = mem_data_q;
        mem_we_d       = 1'b0;
        cpu_hold_d     = cpu_hold_q;
        load_done_d    = load_done_q;
        load_err_d     = load_err_q;
        words_loaded_d = words_loaded_q;
        tmo_d          = tmo_q;

        active = (state_q == SYNC) || (state_q == LEN_HI) || (state_q == LEN_LO) ||
                 (state_q == DATA) || (state_q == CSUM);

        if (rx_valid)                     tmo_d = TMO_RELOAD;
        else if (active && tmo_q != '0)   tmo_d = tmo_q - 1'b1;

        // Bookkeeping for a strobe runs regardless of state so an abort never loses it.
        if (mem_we_q) begin
            words_loaded_d = words_loaded_q + 16'd1;
            mem_addr_d     = mem_addr_q + 32'd4;
        end

        case (state_q)
            IDLE, DONE, ERROR: begin
                if (rx_valid && rx_byte == SYNC_BYTE) begin
                    state_d        = SYNC;
                    cpu_hold_d     = 1'b1;
                    load_done_d    = 1'b0;
                    load_err_d     = 1'b0;
                    words_loaded_d = '0;
                    mem_addr_d     = BASE_ADDR;
                    csum_d         = '0;
                    byte_cnt_d     = '0;
                end
            end
            SYNC: begin
                if (rx_valid) begin
                    len_d   = {rx_byte, 8'h00};
                    state_d = LEN_HI;
                end
            end
            LEN_HI: begin
                if (rx_valid) begin
                    len_d   = {len_q[15:8], rx_byte};
                    state_d = LEN_LO;
                end
            end
            LEN_LO: begin
                if ({16'h0, len_q} > MAX_WORDS) state_d = ERROR;
                else if (len_q == 16'd0)        state_d = CSUM;
                else                            state_d = DATA;
            end
            DATA: begin
                if (rx_valid) begin
                    word_d     = {word_q[15:0], rx_byte};
                    csum_d     = csum_q ^ rx_byte;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        mem_data_d = {word_q, rx_byte};
                        mem_we_d   = 1'b1;
                    end
                end
                if (mem_we_q && (words_loaded_q + 16'd1 == len_q)) state_d = CSUM;
            end
            CSUM: begin
                if (rx_valid) state_d = (rx_byte == csum_q) ? DONE : ERROR;
            end
            default: state_d = IDLE;
        endcase

        // rx_valid outranks an expiring timeout in the same cycle.
        if (active && (frame_err || (tmo_q == '0 && !rx_valid))) state_d = ERROR;

        if (state_d == DONE && state_q != DONE) begin
            cpu_hold_d  = 1'b0;
            load_done_d = 1'b1;
        end
        if (state_d == ERROR && state_q != ERROR) begin
            cpu_hold_d = 1'b0;
            load_err_d = 1'b1;
        end
    end

    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_data  = mem_data_q;
    assign mem.mem_we    = mem_we_q;
    assign cpu_hold      = cpu_hold_q;
    assign load_done     = load_done_q;
    assign load_err      = load_err_q;
    assign words_loaded  = words_loaded_q;
    assign state_dbg     = state_q;

endmodule
